// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared pixel type, image size defaults and 3x3 window indices
package image_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;

  typedef logic [DEF_DATA_W-1:0] pixel_t;

  // Window slot order shared with median3x3: row-major, top-left first
  localparam int WIN_P00 = 0;
  localparam int WIN_P01 = 1;
  localparam int WIN_P02 = 2;
  localparam int WIN_P10 = 3;
  localparam int WIN_P11 = 4;
  localparam int WIN_P12 = 5;
  localparam int WIN_P20 = 6;
  localparam int WIN_P21 = 7;
  localparam int WIN_P22 = 8;
  localparam int WIN_N   = 9;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image line of storage, read returns the value before this cycle's write
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are never reset: the first two rows of a frame overwrite them
  // before any window that depends on them is emitted.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the new column value; the combinational read sees the old one
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/window3x3_gen.sv
// rtl/window3x3_gen.sv - raster stream to 3x3 interior-window generator feeding median3x3
module window3x3_gen
  import image_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] p00,
  output logic [DATA_W-1:0] p01,
  output logic [DATA_W-1:0] p02,
  output logic [DATA_W-1:0] p10,
  output logic [DATA_W-1:0] p11,
  output logic [DATA_W-1:0] p12,
  output logic [DATA_W-1:0] p20,
  output logic [DATA_W-1:0] p21,
  output logic [DATA_W-1:0] p22,
  output logic              frame_done,
  output logic              sof_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]     col_q, col_d, pos_col;
  logic [RW-1:0]     row_q, row_d, pos_row;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              sof_err_q, sof_err_d;
  logic [DATA_W-1:0] win_q [WIN_N];
  logic [DATA_W-1:0] win_d [WIN_N];
  logic [DATA_W-1:0] lb0_rdata, lb1_rdata;

  // lb0 holds the previous row, lb1 the one before; lb1 is fed from lb0's old value
  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(CW)) u_lb0 (
    .clk   (clk),
    .wr_en (in_valid),
    .addr  (pos_col),
    .wdata (in_pixel),
    .rdata (lb0_rdata)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(CW)) u_lb1 (
    .clk   (clk),
    .wr_en (in_valid),
    .addr  (pos_col),
    .wdata (lb0_rdata),
    .rdata (lb1_rdata)
  );

  // Position of the accepted pixel, raster counter advance, window shift and strobes
  always_comb begin
    pos_col      = in_sof ? '0 : col_q;
    pos_row      = in_sof ? '0 : row_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    if (in_valid) begin
      // An in_sof pixel is (0,0), so it can never also be the frame's last pixel
      sof_err_d    = in_sof && ((col_q != '0) || (row_q != '0));
      frame_done_d = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
      out_valid_d  = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
      win_d[WIN_P00] = win_q[WIN_P01];
      win_d[WIN_P01] = win_q[WIN_P02];
      win_d[WIN_P02] = lb1_rdata;
      win_d[WIN_P10] = win_q[WIN_P11];
      win_d[WIN_P11] = win_q[WIN_P12];
      win_d[WIN_P12] = lb0_rdata;
      win_d[WIN_P20] = win_q[WIN_P21];
      win_d[WIN_P21] = win_q[WIN_P22];
      win_d[WIN_P22] = in_pixel;
    end
  end

  // State registers; reset clears counters, strobes and the visible window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= win_d[i];
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign p00 = win_q[WIN_P00];
  assign p01 = win_q[WIN_P01];
  assign p02 = win_q[WIN_P02];
  assign p10 = win_q[WIN_P10];
  assign p11 = win_q[WIN_P11];
  assign p12 = win_q[WIN_P12];
  assign p20 = win_q[WIN_P20];
  assign p21 = win_q[WIN_P21];
  assign p22 = win_q[WIN_P22];

endmodule

// File: tb/tb_window3x3_gen.sv
// tb/tb_window3x3_gen.sv - directed table-driven bench for window3x3_gen on a 5x4 image
module tb_window3x3_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_pixel = '0;
  logic          out_valid, frame_done, sof_err;
  logic [DW-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;

  int checks = 0;
  int errors = 0;
  int win_cnt = 0;

  typedef struct {
    logic sof;
    int   r;
    int   c;
    logic exp_valid;
    logic exp_fd;
    logic exp_err;
  } vec_t;

  vec_t tbl[$];

  window3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .p00        (p00),
    .p01        (p01),
    .p02        (p02),
    .p10        (p10),
    .p11        (p11),
    .p12        (p12),
    .p20        (p20),
    .p21        (p21),
    .p22        (p22),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] act_win();
    return {p00, p01, p02, p10, p11, p12, p20, p21, p22};
  endfunction

  // Window completed by pixel (r,c): entry (i,j) = {row r-2+i, col c-2+j}
  function automatic logic [71:0] exp_win(int r, int c);
    logic [71:0] w;
    logic [3:0]  rr, cc;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = 4'(r - 2 + i);
        cc = 4'(c - 2 + j);
        w[(8 - (i * 3 + j)) * 8 +: 8] = {rr, cc};
      end
    end
    return w;
  endfunction

  function automatic vec_t mk(logic sof, int r, int c, logic err);
    vec_t v;
    v.sof       = sof;
    v.r         = r;
    v.c         = c;
    v.exp_valid = (r >= 2) && (c >= 2);
    v.exp_fd    = (r == H - 1) && (c == W - 1);
    v.exp_err   = err;
    return v;
  endfunction

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present pixel {r,c}, then check the registered outputs just after the edge
  task automatic push(vec_t v, string tag);
    in_valid = 1'b1;
    in_sof   = v.sof;
    in_pixel = {4'(v.r), 4'(v.c)};
    @(posedge clk);
    #1;
    chk($sformatf("%s out_valid r%0d c%0d", tag, v.r, v.c), 72'(out_valid), 72'(v.exp_valid));
    chk($sformatf("%s frame_done r%0d c%0d", tag, v.r, v.c), 72'(frame_done), 72'(v.exp_fd));
    chk($sformatf("%s sof_err r%0d c%0d", tag, v.r, v.c), 72'(sof_err), 72'(v.exp_err));
    if (out_valid) win_cnt++;
    if (v.exp_valid)
      chk($sformatf("%s window r%0d c%0d", tag, v.r, v.c), act_win(), exp_win(v.r, v.c));
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Idle cycle, optionally with a stray in_sof that must be ignored
  task automatic idle(logic stray_sof, string tag);
    in_valid = 1'b0;
    in_sof   = stray_sof;
    in_pixel = 8'hee;
    @(posedge clk);
    #1;
    chk({tag, " idle out_valid"}, 72'(out_valid), 72'(0));
    chk({tag, " idle sof_err"}, 72'(sof_err), 72'(0));
    in_sof = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, " out_valid zero"}, 72'(out_valid), 72'(0));
    chk({tag, " frame_done zero"}, 72'(frame_done), 72'(0));
    chk({tag, " sof_err zero"}, 72'(sof_err), 72'(0));
    chk({tag, " window zero"}, act_win(), 72'(0));
  endtask

  initial begin
    // Two back-to-back frames, each starting with in_sof
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          tbl.push_back(mk((r == 0) && (c == 0), r, c, 1'b0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous frames: windows, line wrap at 0x30/0x31/0x32, frame_done, back-to-back sof
    win_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) push(tbl[i], "cont");
    chk("cont window count", 72'(win_cnt), 72'(12));
    idle(1'b0, "after cont");
    chk("frame_done one cycle", 72'(frame_done), 72'(0));

    // Same frame with random gaps and stray in_sof on idle cycles
    win_cnt = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 1) == 0) break;
          idle(1'($urandom_range(0, 1)), "gap");
        end
        push(mk((r == 0) && (c == 0), r, c, 1'b0), "gap");
      end
    end
    chk("gap window count", 72'(win_cnt), 72'(6));

    // in_sof at (2,1): error pulse, restart, no window until the new frame's (2,2)
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (!(r == 2 && c >= 1)) push(mk((r == 0) && (c == 0), r, c, 1'b0), "presof");
    win_cnt = 0;
    push(mk(1'b1, 0, 0, 1'b1), "midsof");
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r != 0 || c != 0) push(mk(1'b0, r, c, 1'b0), "restart");
    chk("restart window count", 72'(win_cnt), 72'(6));

    // Asynchronous reset during row 2 while a window is being shown
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3 + (r < 2 ? 2 : 0); c++)
        push(mk((r == 0) && (c == 0), r, c, 1'b0), "prerst");
    chk("prerst valid high", 72'(out_valid), 72'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    win_cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        push(mk((r == 0) && (c == 0), r, c, 1'b0), "postrst");
    chk("postrst window count", 72'(win_cnt), 72'(6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
